// File: rtl/game_pkg.sv
// Constants shared by the sequence generator, game controller and score tracker.
package game_pkg;

    localparam logic [1:0] DIFF_EASY = 2'b01;
    localparam logic [1:0] DIFF_MED  = 2'b10;
    localparam logic [1:0] DIFF_HARD = 2'b11;

    localparam int DEF_SEQ_LEN = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_DATA_W  = 4;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        GEN_IDLE,
        GEN_WRITE,
        GEN_DONE
    } genState_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; reset reloads the seed.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic [15:0] q
);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            q <= SEED;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/sequence_generator.sv
// Writer side of the game sequence RAM: on GoGen fills SEQ_LEN words with
// difficulty-limited pseudo-random digits, then pulses FinGen.
module sequence_generator
    import game_pkg::*;
#(
    parameter int          SEQ_LEN = DEF_SEQ_LEN,
    parameter int          ADDR_W  = DEF_ADDR_W,
    parameter int          DATA_W  = DEF_DATA_W,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              GoGen,
    input  logic [1:0]        Diff,
    output logic              RAMWrEn,
    output logic [ADDR_W-1:0] RAMAddr,
    output logic [DATA_W-1:0] RAMData,
    output logic              FinGen,
    output logic              Busy
);

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(SEQ_LEN - 1);

    genState_t         state, nextState;
    logic [ADDR_W:0]   cnt, nextCnt;
    logic [1:0]        diffLat, nextDiff;
    logic              nextWrEn, nextFin, nextBusy;
    logic [ADDR_W-1:0] nextAddr;
    logic [DATA_W-1:0] nextData;
    logic [15:0]       lfsrQ;
    logic [3:0]        digitNow;

    lfsr16 #(.SEED(SEED)) uLfsr (
        .Clk (Clk),
        .Rst (Rst),
        .q   (lfsrQ)
    );

    // The 0..9 fold of a 4-bit value is slightly biased toward 0..5; that is accepted.
    function automatic logic [3:0] reduceDigit(input logic [3:0] r, input logic [1:0] d);
        case (d)
            DIFF_MED:  return {1'b0, r[2:0]};
            DIFF_HARD: return (r >= 4'd10) ? (r - 4'd10) : r;
            default:   return {2'b00, r[1:0]};
        endcase
    endfunction

    assign digitNow = reduceDigit(lfsrQ[3:0], diffLat);

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        nextDiff  = diffLat;
        nextWrEn  = 1'b0;
        nextAddr  = RAMAddr;
        nextData  = RAMData;
        nextFin   = 1'b0;
        nextBusy  = (state != GEN_IDLE);
        case (state)
            GEN_IDLE: begin
                if (GoGen) begin
                    nextState = GEN_WRITE;
                    nextCnt   = '0;
                    nextDiff  = (Diff == 2'b00) ? DIFF_EASY : Diff;
                end
            end
            GEN_WRITE: begin
                nextWrEn = 1'b1;
                nextAddr = cnt[ADDR_W-1:0];
                nextData = DATA_W'(digitNow);
                nextCnt  = cnt + 1'b1;
                if (cnt == LAST_ADDR) begin
                    nextState = GEN_DONE;
                end
            end
            GEN_DONE: begin
                nextFin   = 1'b1;
                nextState = GEN_IDLE;
            end
            default: nextState = GEN_IDLE;
        endcase
    end

    // Every output is a register so the controller never sees a combinational path from GoGen.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= GEN_IDLE;
            cnt     <= '0;
            diffLat <= DIFF_EASY;
            RAMWrEn <= 1'b0;
            RAMAddr <= '0;
            RAMData <= '0;
            FinGen  <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            state   <= nextState;
            cnt     <= nextCnt;
            diffLat <= nextDiff;
            RAMWrEn <= nextWrEn;
            RAMAddr <= nextAddr;
            RAMData <= nextData;
            FinGen  <= nextFin;
            Busy    <= nextBusy;
        end
    end

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: table of fills plus hand-written
// reset-abort and back-to-back sequences, checked against a reference LFSR.
module tb_sequence_generator;

    logic       Clk;
    logic       Rst;
    logic       GoGen;
    logic [1:0] Diff;
    logic       RAMWrEn;
    logic [4:0] RAMAddr;
    logic [3:0] RAMData;
    logic       FinGen;
    logic       Busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] refLfsr;
    logic [15:0] refPrev;
    logic [3:0]  capSeq [32];
    logic [3:0]  seqA   [32];
    logic [3:0]  seqB   [32];

    typedef struct {
        logic [1:0] diff;
        int         maxDigit;
        int         idleCycles;
        bit         doReset;
        int         injectAt;
        int         saveSlot;
        string      tag;
    } fillVec_t;

    fillVec_t vecs [7];

    sequence_generator dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .GoGen   (GoGen),
        .Diff    (Diff),
        .RAMWrEn (RAMWrEn),
        .RAMAddr (RAMAddr),
        .RAMData (RAMData),
        .FinGen  (FinGen),
        .Busy    (Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [15:0] stepLfsr(input logic [15:0] q);
        logic [15:0] s;
        s = q >> 1;
        if (q[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    function automatic int expDigit(input logic [15:0] r, input logic [1:0] d);
        int n;
        n = int'(r[3:0]);
        if (d == 2'b11) return (n >= 10) ? n - 10 : n;
        if (d == 2'b10) return n % 8;
        return n % 4;
    endfunction

    // Reference LFSR tracks the DUT's; refPrev is the value that fed the latest edge.
    always @(posedge Clk) begin
        refPrev <= refLfsr;
        if (Rst) refLfsr <= 16'hACE1;
        else     refLfsr <= stepLfsr(refLfsr);
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyReset();
        Rst   = 1'b1;
        GoGen = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        checkOutput("resetOutputs", {RAMWrEn, FinGen, Busy, RAMAddr, RAMData}, 0);
        Rst = 1'b0;
    endtask

    task automatic runFill(input logic [1:0] diffIn, input int maxDigit, input int injectAt,
                           input string tag);
        int writes, addrErr, rangeErr, refErr, finCnt, finAt, busyCnt;
        logic [1:0] latched;
        latched = (diffIn == 2'b00) ? 2'b01 : diffIn;
        writes = 0; addrErr = 0; rangeErr = 0; refErr = 0;
        finCnt = 0; finAt = -1; busyCnt = 0;
        GoGen = 1'b1;
        Diff  = diffIn;
        @(negedge Clk);
        GoGen = 1'b0;
        for (int cyc = 1; cyc <= 36; cyc++) begin
            @(negedge Clk);
            if (RAMWrEn) begin
                if (writes < 32) capSeq[writes] = RAMData;
                if (RAMAddr != 5'(writes)) addrErr++;
                if (int'(RAMData) > maxDigit) rangeErr++;
                if (int'(RAMData) != expDigit(refPrev, latched)) refErr++;
                writes++;
            end
            if (FinGen) begin
                finCnt++;
                if (finAt < 0) finAt = cyc;
            end
            if (Busy) busyCnt++;
            if (cyc == injectAt) begin
                GoGen = 1'b1;
                Diff  = 2'b11;
            end else if (cyc == injectAt + 1) begin
                GoGen = 1'b0;
            end
        end
        checkOutput({tag, ".writes"}, writes, 32);
        checkOutput({tag, ".addrOrderErrs"}, addrErr, 0);
        checkOutput({tag, ".rangeErrs"}, rangeErr, 0);
        checkOutput({tag, ".refLfsrErrs"}, refErr, 0);
        checkOutput({tag, ".finCount"}, finCnt, 1);
        checkOutput({tag, ".finCycle"}, finAt, 33);
        checkOutput({tag, ".busyCycles"}, busyCnt, 33);
    endtask

    task automatic applyStimulus(input fillVec_t v);
        if (v.doReset) applyReset();
        for (int i = 0; i < v.idleCycles; i++) @(negedge Clk);
        runFill(v.diff, v.maxDigit, v.injectAt, v.tag);
        if (v.saveSlot == 1) for (int i = 0; i < 32; i++) seqA[i] = capSeq[i];
        if (v.saveSlot == 2) for (int i = 0; i < 32; i++) seqB[i] = capSeq[i];
    endtask

    initial begin
        int found, finCnt, wrCnt, diffWords, finAt, gapWr, gapAddr;
        Rst   = 1'b1;
        GoGen = 1'b0;
        Diff  = 2'b00;

        vecs[0] = '{2'b11, 9, 0, 1'b1, -1, 0, "hardFirst"};
        vecs[1] = '{2'b01, 3, 2, 1'b0, -1, 0, "easy"};
        vecs[2] = '{2'b10, 7, 3, 1'b0, -1, 0, "medium"};
        vecs[3] = '{2'b00, 3, 1, 1'b0, -1, 0, "diff00"};
        vecs[4] = '{2'b01, 3, 0, 1'b0, 11, 0, "midFillGoDiff"};
        vecs[5] = '{2'b11, 9, 5, 1'b1, -1, 1, "delay5"};
        vecs[6] = '{2'b11, 9, 6, 1'b1, -1, 2, "delay6"};

        for (int k = 0; k < 7; k++) applyStimulus(vecs[k]);

        diffWords = 0;
        for (int i = 0; i < 32; i++) if (seqA[i] != seqB[i]) diffWords++;
        checkOutput("delaySeqsDiffer", int'(diffWords > 0), 1);

        // Reset during a fill aborts it immediately, then a new fill restarts at 0.
        found = 0;
        GoGen = 1'b1;
        Diff  = 2'b01;
        @(negedge Clk);
        GoGen = 1'b0;
        for (int cyc = 0; cyc < 40 && found == 0; cyc++) begin
            @(negedge Clk);
            if (RAMWrEn && RAMAddr == 5'd15) found = 1;
        end
        checkOutput("reachAddr15", found, 1);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        checkOutput("abortWrEn", int'(RAMWrEn), 0);
        checkOutput("abortBusy", int'(Busy), 0);
        checkOutput("abortFin", int'(FinGen), 0);
        finCnt = 0;
        wrCnt  = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge Clk);
            if (FinGen) finCnt++;
            if (RAMWrEn) wrCnt++;
        end
        checkOutput("abortNoFin", finCnt, 0);
        checkOutput("abortNoWrites", wrCnt, 0);
        runFill(2'b10, 7, -1, "afterAbort");

        // GoGen held high: second fill's first write lands two cycles after FinGen.
        finCnt  = 0;
        finAt   = -1;
        gapWr   = -1;
        gapAddr = -1;
        GoGen   = 1'b1;
        Diff    = 2'b11;
        @(negedge Clk);
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge Clk);
            if (FinGen) begin
                finCnt++;
                if (finAt < 0) finAt = cyc;
            end
            if (finAt > 0 && cyc > finAt && gapWr < 0 && RAMWrEn) begin
                gapWr   = cyc - finAt;
                gapAddr = int'(RAMAddr);
            end
            if (finAt > 0 && cyc == finAt + 3) GoGen = 1'b0;
        end
        checkOutput("b2bFirstFin", finAt, 33);
        checkOutput("b2bGap", gapWr, 2);
        checkOutput("b2bRestartAddr", gapAddr, 0);
        checkOutput("b2bFinCount", finCnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
